// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: instruction formats, opcode constants and the
// opcode-to-format mapping used by both the encoder and the immediate generator.
package riscv_pkg;

  typedef enum logic [2:0] {R, I, S, B, U, J, ILLEGAL} instr_type_t;

  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_IMM    = 7'd19;
  localparam logic [6:0] OP_AUIPC  = 7'd23;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_REG    = 7'd51;
  localparam logic [6:0] OP_LUI    = 7'd55;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_JALR   = 7'd103;
  localparam logic [6:0] OP_JAL    = 7'd111;

  function automatic instr_type_t instr_type_of(input logic [6:0] opcode);
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR: instr_type_of = I;
      OP_AUIPC, OP_LUI:         instr_type_of = U;
      OP_STORE:                 instr_type_of = S;
      OP_REG:                   instr_type_of = R;
      OP_BRANCH:                instr_type_of = B;
      OP_JAL:                   instr_type_of = J;
      default:                  instr_type_of = ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/imm_packer.sv
// Range-checks an immediate for its format and scatters its bits into the
// instruction-word positions; all non-immediate bit positions are left zero.
module imm_packer
  import riscv_pkg::*;
(
  input  instr_type_t itype,
  input  logic        is_op_imm,
  input  logic [2:0]  funct3,
  input  logic [31:0] imm,
  output logic [31:0] imm_bits,
  output logic        legal,
  output logic        is_shift
);

  always_comb begin
    imm_bits = '0;
    legal    = 1'b0;
    is_shift = (itype == I) && is_op_imm && ((funct3 == 3'b001) || (funct3 == 3'b101));
    case (itype)
      I: begin
        if (is_shift) begin
          legal           = (imm[31:5] == 27'd0);
          imm_bits[24:20] = imm[4:0];
        end else begin
          legal           = (imm[31:11] == {21{imm[11]}});
          imm_bits[31:20] = imm[11:0];
        end
      end
      S: begin
        legal           = (imm[31:11] == {21{imm[11]}});
        imm_bits[31:25] = imm[11:5];
        imm_bits[11:7]  = imm[4:0];
      end
      B: begin
        legal           = (imm[31:12] == {20{imm[12]}}) && !imm[0];
        imm_bits[31]    = imm[12];
        imm_bits[30:25] = imm[10:5];
        imm_bits[11:8]  = imm[4:1];
        imm_bits[7]     = imm[11];
      end
      U: begin
        legal           = (imm[11:0] == 12'd0);
        imm_bits[31:12] = imm[31:12];
      end
      J: begin
        legal           = (imm[31:20] == {12{imm[20]}}) && !imm[0];
        imm_bits[31]    = imm[20];
        imm_bits[30:21] = imm[10:1];
        imm_bits[20]    = imm[11];
        imm_bits[19:12] = imm[19:12];
      end
      R:       legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instruction_encoder.sv
// Captures a decoded field bundle, validates and packs it into an RV32I word,
// and presents the word with its instruction-memory byte address.
module instruction_encoder
  import riscv_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  input  logic        clear,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {IDLE, CHECK, EMIT} state_t;

  localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * (MEM_WORDS - 1));

  state_t      state_reg, state_next;
  logic [6:0]  opcode_reg, funct7_reg;
  logic [4:0]  rd_reg, rs1_reg, rs2_reg;
  logic [2:0]  funct3_reg;
  logic [31:0] imm_reg;
  logic [31:0] instr_reg, addr_reg;
  logic        err_reg;
  logic [7:0]  err_count_reg;

  instr_type_t itype;
  logic [31:0] imm_bits, packed_word;
  logic        legal, is_shift;
  logic        accept, reject, handshake;

  assign itype = instr_type_of(opcode_reg);

  imm_packer u_imm_packer (
    .itype     (itype),
    .is_op_imm (opcode_reg == OP_IMM),
    .funct3    (funct3_reg),
    .imm       (imm_reg),
    .imm_bits  (imm_bits),
    .legal     (legal),
    .is_shift  (is_shift)
  );

  // Register fields are inserted only where the format defines them, so
  // stray values on unused inputs never leak into the word.
  always_comb begin
    packed_word      = imm_bits;
    packed_word[6:0] = opcode_reg;
    if (itype inside {R, I, U, J}) packed_word[11:7]  = rd_reg;
    if (itype inside {R, I, S, B}) packed_word[19:15] = rs1_reg;
    if (itype inside {R, S, B})    packed_word[24:20] = rs2_reg;
    if (itype inside {R, I, S, B}) packed_word[14:12] = funct3_reg;
    if ((itype == R) || is_shift)  packed_word[31:25] = funct7_reg;
  end

  assign accept    = (state_reg == IDLE) && in_valid && !clear;
  assign reject    = (state_reg == CHECK) && !legal && !clear;
  assign handshake = (state_reg == EMIT) && out_ready && !clear;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = CHECK;
      CHECK:   state_next = legal ? EMIT : IDLE;
      EMIT:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      opcode_reg    <= '0;
      funct7_reg    <= '0;
      rd_reg        <= '0;
      rs1_reg       <= '0;
      rs2_reg       <= '0;
      funct3_reg    <= '0;
      imm_reg       <= '0;
      instr_reg     <= '0;
      addr_reg      <= BASE_ADDR;
      err_reg       <= 1'b0;
      err_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      err_reg   <= reject;
      if (accept) begin
        opcode_reg <= opcode;
        funct7_reg <= funct7;
        rd_reg     <= rd;
        rs1_reg    <= rs1;
        rs2_reg    <= rs2;
        funct3_reg <= funct3;
        imm_reg    <= imm;
      end
      if ((state_reg == CHECK) && legal && !clear) instr_reg <= packed_word;
      if (reject && (err_count_reg != 8'hFF)) err_count_reg <= err_count_reg + 8'd1;
      if (clear)
        addr_reg <= BASE_ADDR;
      else if (handshake)
        addr_reg <= (addr_reg == LAST_ADDR) ? BASE_ADDR : addr_reg + 32'd4;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == EMIT);
  assign out_instr = instr_reg;
  assign out_addr  = addr_reg;
  assign err       = err_reg;
  assign err_count = err_count_reg;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder with a 4-word address window so the
// wrap path is exercised; expected words are hand-encoded RV32I constants.
module tb_instruction_encoder;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          WORDS = 4;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, clear, out_valid, out_ready, err;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm, out_instr, out_addr;
  logic [7:0]  err_count;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_addr = BASE;
  logic [31:0] exp_errs = 0;

  always #5 clk = ~clk;

  instruction_encoder #(.BASE_ADDR(BASE), .MEM_WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .imm(imm), .clear(clear), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .err(err), .err_count(err_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives one bundle at a negedge; returns at the negedge of the cycle after CHECK.
  task automatic send(input logic [6:0] op, input logic [4:0] rd_v, input logic [4:0] rs1_v,
                      input logic [4:0] rs2_v, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] imm_v);
    check("in_ready_idle", in_ready, 1);
    opcode = op; rd = rd_v; rs1 = rs1_v; rs2 = rs2_v; funct3 = f3; funct7 = f7; imm = imm_v;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
    check("check_no_valid", out_valid, 0);
    check("check_in_ready", in_ready, 0);
    @(negedge clk);
  endtask

  task automatic expect_word(input string tag, input logic [31:0] instr, input int hold);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_instr"}, out_instr, instr);
    check({tag, "_addr"}, out_addr, exp_addr);
    check({tag, "_in_ready"}, in_ready, 0);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_instr"}, out_instr, instr);
      check({tag, "_hold_addr"}, out_addr, exp_addr);
      check({tag, "_hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    $display("emit %s instr=%h addr=%h", tag, instr, exp_addr);
    exp_addr = BASE + ((exp_addr - BASE + 32'd4) % (4 * WORDS));
    check({tag, "_done_valid"}, out_valid, 0);
    check({tag, "_next_addr"}, out_addr, exp_addr);
  endtask

  task automatic expect_reject(input string tag);
    exp_errs++;
    check({tag, "_err"}, err, 1);
    check({tag, "_no_valid"}, out_valid, 0);
    check({tag, "_err_count"}, err_count, exp_errs);
    check({tag, "_addr"}, out_addr, exp_addr);
    @(negedge clk);
    check({tag, "_err_pulse_end"}, err, 0);
    check({tag, "_still_no_valid"}, out_valid, 0);
    $display("reject %s err_count=%0d", tag, exp_errs);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
    opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_instr", out_instr, 0);
    check("rst_out_addr", out_addr, BASE);
    check("rst_err", err, 0);
    check("rst_err_count", err_count, 0);
    rst_n = 1'b1;
    @(negedge clk);

    send(7'd19, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    expect_word("addi", 32'hFFF0_0093, 0);
    send(7'd35, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    expect_word("sw", 32'h0020_A423, 5);

    clear = 1'b1; @(negedge clk); clear = 1'b0;
    exp_addr = BASE;
    check("clear_idle_addr", out_addr, BASE);
    send(7'd99, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
    expect_word("beq", 32'hFE00_0EE3, 0);
    // Junk on fields U-type does not use must not reach the word.
    send(7'd55, 5'd5, 5'd7, 5'd9, 3'd3, 7'h7F, 32'h1234_5000);
    expect_word("lui", 32'h1234_52B7, 0);

    send(7'd111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    expect_reject("jal_odd");
    send(7'd19, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    expect_reject("addi_range");
    send(7'd127, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    expect_reject("bad_opcode");
    send(7'd19, 5'd1, 5'd1, 5'd0, 3'd1, 7'd0, 32'd32);
    expect_reject("slli_range");

    clear = 1'b1; @(negedge clk); clear = 1'b0;
    exp_addr = BASE;
    check("clear_keeps_err_count", err_count, exp_errs);
    send(7'd51, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEAD_BEEF);
    expect_word("add", 32'h0020_81B3, 0);
    send(7'd111, 5'd1, 5'd3, 5'd4, 3'd7, 7'd0, 32'd8);
    expect_word("jal", 32'h0080_00EF, 0);
    send(7'd19, 5'd1, 5'd1, 5'd0, 3'd1, 7'd0, 32'd3);
    expect_word("slli", 32'h0030_9093, 0);
    send(7'd19, 5'd2, 5'd2, 5'd0, 3'd5, 7'h20, 32'd31);
    expect_word("srai", 32'h41F1_5113, 0);
    send(7'd23, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1000);
    expect_word("auipc_wrap", 32'h0000_1217, 0);

    send(7'd19, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    check("pre_clear_valid", out_valid, 1);
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    exp_addr = BASE;
    check("clear_drops_valid", out_valid, 0);
    check("clear_addr", out_addr, BASE);
    check("clear_err_count", err_count, exp_errs);
    $display("clear during emit addr=%h", out_addr);

    send(7'd35, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    expect_word("sw_pre_rst", 32'h0020_A423, 0);
    send(7'd19, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    check("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_out_instr", out_instr, 0);
    check("arst_out_addr", out_addr, BASE);
    check("arst_err", err, 0);
    check("arst_err_count", err_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_no_valid", out_valid, 0);
    end
    $display("reset during emit, nothing emitted after release");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

Assembles RISC-V RV32I instruction words from decoded fields. It is the inverse of the core's immediate generator: it range-checks the immediate and scatters its bits into the format selected by the opcode. It then emits the 32-bit word with a word address, through valid/ready handshakes. It sits between the test/boot loader front end and the instruction-memory write port.

## Interface
- BASE_ADDR, 32'h0000_0000: byte address of the first emitted word.
- MEM_WORDS, 256: emit-address window size in words; power of two.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  block can accept a bundle.
- opcode  in  7  instruction opcode.
- rd, rs1, rs2  in  5 each  register fields.
- funct3  in  3  funct3 field.
- funct7  in  7  funct7 field.
- imm  in  32  immediate value, as the immediate generator would output it.
- clear  in  1  synchronous restart: address back to BASE_ADDR, state to IDLE.
- out_valid  out  1  word valid.
- out_ready  in  1  consumer accepts word.
- out_instr  out  32  encoded instruction.
- out_addr  out  32  byte address of out_instr.
- err  out  1  one-cycle pulse when a bundle is rejected.
- err_count  out  8  rejected bundles; saturates at 255.

## Operation
- Format from opcode:
  - I: 3, 19, 103.
  - U: 23, 55.
  - S: 35.
  - R: 51.
  - B: 99.
  - J: 111.
  - Any other opcode is illegal and rejected.
- Legal immediates:
  - I: imm sign-extends from bit 11.
  - Shift-I (opcode 19, funct3 001/101): imm in 0..31. funct7 goes to [31:25], imm[4:0] to [24:20].
  - S: imm sign-extends from bit 11.
  - B: imm sign-extends from bit 12, and imm[0]=0.
  - J: imm sign-extends from bit 20, and imm[0]=0.
  - U: imm[11:0]=0.
  - R: imm is ignored.
- Any other immediate is rejected.
- Packing (opcode always at [6:0]):
  - I: imm[11:0] to [31:20].
  - S: imm[11:5] to [31:25]; imm[4:0] to [11:7].
  - B: imm[12] to 31; imm[10:5] to [30:25]; imm[4:1] to [11:8]; imm[11] to 7.
  - U: imm[31:12] to [31:12].
  - J: imm[20] to 31; imm[10:1] to [30:21]; imm[11] to 20; imm[19:12] to [19:12].
  - R: funct7, rs2, rs1, funct3, rd in their standard positions.
- Field usage by format:
  - rd: R, I, U, J only.
  - rs1: R, I, S, B only.
  - rs2: R, S, B only.
  - funct3: R, I, S, B only.
  - Unused fields are zero in out_instr.
- FSM states: IDLE, CHECK, EMIT.
  - IDLE: in_ready=1. in_valid captures all fields into registers and moves to CHECK.
  - CHECK: in_ready=0. Validate and pack.
    - Legal: load out_instr, go to EMIT.
    - Illegal: pulse err, increment err_count (saturating), return to IDLE.
  - EMIT: out_valid=1 while waiting. out_ready completes the handshake, returns to IDLE and advances out_addr by 4.
- Address wrap: from BASE_ADDR+4*(MEM_WORDS-1) back to BASE_ADDR.
- Output stability: out_instr and out_addr hold stable while out_valid=1 and out_ready=0.
- clear: takes priority over everything in the same cycle.
  - Drops any in-flight word, goes to IDLE, sets out_addr=BASE_ADDR.
  - err_count is kept.
- Reset values:
  - state IDLE, in_ready=1, out_valid=0.
  - out_instr=0, out_addr=BASE_ADDR.
  - err=0, err_count=0.
- Reset asserted mid-EMIT discards the word immediately; nothing is emitted after release.

## Timing
- Latency: 2 cycles from accept (in_valid && in_ready) to out_valid.
- Throughput: at most one bundle per 3 cycles with out_ready held high.
- err is asserted in the cycle after the CHECK cycle and lasts exactly 1 cycle.
- err_count updates in the same cycle as the err pulse.
- out_addr updates in the cycle after the output handshake. It always names the word currently presented.
- All outputs are registered; there are no combinational in-to-out paths.

## Structure
- Shared package riscv_pkg holds:
  - instr_type_t enum {R, I, S, B, U, J, ILLEGAL}.
  - opcode constants OP_LOAD=3, OP_IMM=19, OP_AUIPC=23, OP_STORE=35, OP_REG=51, OP_LUI=55, OP_BRANCH=99, OP_JALR=103, OP_JAL=111.
  - A function mapping opcode to instr_type_t. The immediate generator shares this function.
- One combinational sub-module, imm_packer: takes type, funct3 and imm; returns the packed immediate bits and a legal flag.
- The top level holds the FSM, the capture registers, the address counter and the error counter.

## Test plan
- addi: opcode 19, rd=1, rs1=0, funct3=0, imm=32'hFFFF_FFFF. Expect out_instr=32'hFFF0_0093 at out_addr=BASE_ADDR, 2 cycles after accept.
- sw: opcode 35, rs1=1, rs2=2, funct3=2, imm=8. Expect 32'h0020_A423. With out_ready held low 5 cycles, out_instr/out_addr stay stable and in_ready=0.
- beq: opcode 99, rs1=0, rs2=0, funct3=0, imm=-4. Expect 32'hFE00_0EE3. Then lui: opcode 55, rd=5, imm=32'h1234_5000. Expect 32'h1234_52B7 at BASE_ADDR+4.
- Rejects, one after another:
  - jal with imm=3.
  - addi with imm=2048.
  - opcode 127.
  - Expect three err pulses, err_count=3, no out_valid, out_addr unchanged.
- MEM_WORDS=4: emit 5 words. Expect addresses BASE+0, +4, +8, +12, +0.
- Two interrupts:
  - clear asserted during EMIT: out_valid drops next cycle and out_addr=BASE_ADDR.
  - rst_n low during EMIT: all outputs take reset values immediately.
